square_seq: RTL and testbench

//  Sequential shift-add squarer: result = A*A, unsigned, one multiplier bit per cycle.

---
 rtl/square_seq_if.sv | 14 +
 rtl/square_seq.sv | 92 +++++++++
 tb/tb_square_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/square_seq_if.sv
// Start/finish handshake and operand/result bus of the sequential squarer.
// The master issues requests and the slave (the squarer) answers them.
interface square_seq_if #(
  parameter int WIDTH = 16
);
  logic               init;
  logic [WIDTH-1:0]   A;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               done;

  modport master (output init, A, input result, busy, done);
  modport slave  (input init, A, output result, busy, done);
endinterface

// File: rtl/square_seq.sv
// Shift-add squarer: result = A*A, one multiplier bit per cycle, fixed latency.
// Its init/done handshake matches the iterative root core, so both fit the same wrapper.
module square_seq #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  square_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.init) begin
          op_d    = bus.A;
          state_d = LOAD;
        end
      end
      LOAD: begin
        mcand_d  = {{WIDTH{1'b0}}, op_q};
        mplier_d = op_q;
        acc_d    = '0;
        count_d  = CW'(WIDTH);
        state_d  = ITER;
      end
      ITER: begin
        // Partial products of A*A never exceed 2*WIDTH bits, so no carry is lost.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_d == '0) begin
          result_d = acc_d;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered alongside the state they describe.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_square_seq.sv
// Directed and randomized checks of square_seq against plain A*A arithmetic
// and an integer square-root loopback over all 8-bit operands.
module tb_square_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  square_seq_if #(.WIDTH(W)) bus ();

  square_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint ref_sq(input longint a);
    return a * a;
  endfunction

  function automatic longint isqrt(input longint v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Called and returns at a negedge; lat counts edges from the accepting edge (=1) to done.
  task automatic run_op(input logic [W-1:0] a, output logic [2*W-1:0] res, output int lat);
    int guard = 0;
    while (bus.busy !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.A    = a;
    bus.init = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.init = 1'b0;
    bus.A    = W'($urandom);
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = bus.result;
    if (lat >= 40) check("timeout", 64'(lat), 64'(18));
  endtask

  initial begin
    logic [2*W-1:0] res;
    int             lat;
    int             n, d1, d2;
    logic           seen;
    logic [W-1:0]   a;
    logic [W-1:0]   dir_a [3];
    logic [2*W-1:0] dir_r [3];
    bit             loop_ok;

    dir_a[0] = 16'h00FF; dir_r[0] = 32'h0000_FE01;
    dir_a[1] = 16'h0003; dir_r[1] = 32'h0000_0009;
    dir_a[2] = 16'hFFFF; dir_r[2] = 32'hFFFE_0001;

    // 1: reset with init held high
    rst = 1'b1; bus.init = 1'b1; bus.A = 16'h0005;
    @(posedge clk); @(negedge clk);
    check("rst_busy_during", 64'(bus.busy), 64'(0));
    @(posedge clk); @(negedge clk);
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    rst = 1'b0; bus.init = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_idle", 64'(bus.busy), 64'(0));

    // 2: zero operand, fixed latency
    run_op(16'h0000, res, lat);
    check("zero_lat", 64'(lat), 64'(18));
    check("zero_res", 64'(res), 64'(0));
    @(posedge clk); @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'(0));
    check("result_held", 64'(bus.result), 64'(0));

    // 3: directed operands including the full-scale one
    for (int i = 0; i < 3; i++) begin
      run_op(dir_a[i], res, lat);
      check($sformatf("dir_res_%0h", dir_a[i]), 64'(res), 64'(dir_r[i]));
      check($sformatf("dir_lat_%0h", dir_a[i]), 64'(lat), 64'(18));
    end
    @(negedge clk);

    // 4: init held high for back-to-back operations; A changes after acceptance
    bus.A = 16'd5; bus.init = 1'b1;
    @(posedge clk);
    n = 1; d1 = 0; d2 = 0;
    @(negedge clk);
    bus.A = 16'd7;
    while (d2 == 0 && n < 60) begin
      if (bus.done === 1'b1) begin
        if (d1 == 0) begin
          d1 = n;
          check("b2b_res1", 64'(bus.result), 64'(ref_sq(5)));
        end else begin
          d2 = n;
          check("b2b_res2", 64'(bus.result), 64'(ref_sq(7)));
          bus.init = 1'b0;
        end
      end
      if (d2 == 0) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
    bus.init = 1'b0;
    check("b2b_lat1", 64'(d1), 64'(18));
    check("b2b_spacing", 64'(d2 - d1), 64'(19));
    @(negedge clk);

    // 5: reset during iteration 8 aborts without a done pulse
    bus.A = 16'h1234; bus.init = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.init = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("abort_result", 64'(bus.result), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen |= bus.done;
      @(negedge clk);
    end
    check("abort_no_done", 64'(seen), 64'(0));
    run_op(16'd12, res, lat);
    check("after_abort_res", 64'(res), 64'(ref_sq(12)));
    check("after_abort_lat", 64'(lat), 64'(18));

    // 6: random sweep
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      run_op(a, res, lat);
      check($sformatf("rand_%0h", a), 64'(res), 64'(ref_sq(longint'(a))));
    end

    // loopback: integer root of each 8-bit square returns the operand
    loop_ok = 1'b1;
    for (int x = 0; x < 256; x++) begin
      run_op(W'(x), res, lat);
      if (isqrt(longint'(res)) != longint'(x)) begin
        loop_ok = 1'b0;
        check($sformatf("loop_%0d", x), 64'(isqrt(longint'(res))), 64'(x));
      end
    end
    check("loopback_all", 64'(loop_ok), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
